// File: rtl/psum_route_fabric.sv
// Programmable psum routing fabric: one registered hop per PE, a segment-start map, and a drain-then-apply reconfiguration FSM.
// Optional per-column stall counters are built when PSUM_FABRIC_STALL_CNT_EN is defined.
module psum_route_fabric #(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int DW      = 16,
    parameter int STALL_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ROWS*COLS*DW-1:0] pe_psum_out,
    input  logic [ROWS*COLS-1:0]    pe_psum_out_vld,
    output logic [ROWS*COLS-1:0]    pe_psum_out_ack,
    output logic [ROWS*COLS*DW-1:0] pe_psum_in,
    output logic [ROWS*COLS-1:0]    pe_psum_in_vld,
    input  logic [ROWS*COLS-1:0]    pe_psum_in_ack,
    input  logic [COLS*DW-1:0]      ext_psum_in,
    input  logic [COLS-1:0]         ext_psum_in_vld,
    output logic [COLS-1:0]         ext_psum_in_ack,
    output logic [ROWS*COLS*DW-1:0] seg_out,
    output logic [ROWS*COLS-1:0]    seg_out_vld,
    input  logic [ROWS*COLS-1:0]    seg_out_ack,
    input  logic [ROWS-1:0]         cfg_seg_start,
    input  logic                    cfg_top_ext,
    input  logic                    cfg_req,
    output logic                    cfg_busy,
    output logic                    cfg_done,
    output logic [COLS*STALL_W-1:0] stall_cnt,
    output logic                    err
);
    localparam int N = ROWS * COLS;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_APPLY} state_t;

    state_t          state, state_nxt;
    logic [ROWS-1:0] seg_start, seg_start_shd;
    logic            top_ext, top_ext_shd;
    logic [ROWS-1:0] seg_end;
    logic [N-1:0]    hop_full, cons_ack, accept, drain;
    logic [DW-1:0]   hop_data [N];
    logic            run;

    // Gating with rst_n keeps every combinational vld/ack low while reset is held.
    assign run      = (state == ST_RUN) && rst_n;
    assign cfg_busy = (state != ST_RUN);

    // NOTE: next-state logic assigns its default first so no path leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RUN:   if (cfg_req) state_nxt = ST_DRAIN;
            ST_DRAIN: if (hop_full == '0) state_nxt = ST_APPLY;
            ST_APPLY: state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_RUN;
            seg_start     <= ROWS'(1);
            top_ext       <= 1'b0;
            seg_start_shd <= ROWS'(1);
            top_ext_shd   <= 1'b0;
            cfg_done      <= 1'b0;
            err           <= 1'b0;
        end else begin
            state    <= state_nxt;
            cfg_done <= (state == ST_APPLY);
            if (cfg_req && cfg_busy) err <= 1'b1;
            if (state == ST_RUN && cfg_req) begin
                seg_start_shd <= {cfg_seg_start[ROWS-1:1], 1'b1};
                top_ext_shd   <= cfg_top_ext;
            end
            if (state == ST_APPLY) begin
                seg_start <= seg_start_shd;
                top_ext   <= top_ext_shd;
            end
        end
    end

    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        if (gr == ROWS - 1) begin : g_last
            assign seg_end[gr] = 1'b1;
        end else begin : g_mid
            assign seg_end[gr] = seg_start[gr+1];
        end

        for (genvar gc = 0; gc < COLS; gc++) begin : g_col
            localparam int I = gr * COLS + gc;

            if (gr == ROWS - 1) begin : g_ack_last
                assign cons_ack[I] = seg_out_ack[I];
            end else begin : g_ack_mid
                assign cons_ack[I] = seg_end[gr] ? seg_out_ack[I] : pe_psum_in_ack[I+COLS];
            end

            assign drain[I]           = hop_full[I] & cons_ack[I];
            assign accept[I]          = run & pe_psum_out_vld[I] & (~hop_full[I] | cons_ack[I]);
            assign pe_psum_out_ack[I] = accept[I];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)         hop_full[I] <= 1'b0;
                else if (accept[I]) hop_full[I] <= 1'b1;
                else if (drain[I])  hop_full[I] <= 1'b0;
            end

            // NOTE: the data word is qualified by hop_full, so it needs no reset.
            always_ff @(posedge clk) begin
                if (accept[I]) hop_data[I] <= pe_psum_out[I*DW +: DW];
            end

            assign seg_out[I*DW +: DW] = hop_data[I];
            assign seg_out_vld[I]      = hop_full[I] & seg_end[gr];

            if (gr == 0) begin : g_src_top
                assign pe_psum_in[I*DW +: DW] = top_ext ? ext_psum_in[gc*DW +: DW] : '0;
                assign pe_psum_in_vld[I]      = run & (top_ext ? ext_psum_in_vld[gc] : 1'b1);
                assign ext_psum_in_ack[gc]    = run & top_ext & pe_psum_in_ack[I];
            end else begin : g_src_hop
                assign pe_psum_in[I*DW +: DW] = seg_start[gr] ? '0 : hop_data[I-COLS];
                assign pe_psum_in_vld[I]      = seg_start[gr] ? run : hop_full[I-COLS];
            end
        end
    end

`ifdef PSUM_FABRIC_STALL_CNT_EN
    logic [COLS-1:0] stall_col;

    always_comb begin
        stall_col = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                stall_col[c] = stall_col[c] | (hop_full[r*COLS+c] & ~cons_ack[r*COLS+c]);
            end
        end
    end

    for (genvar gc = 0; gc < COLS; gc++) begin : g_stall
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                stall_cnt[gc*STALL_W +: STALL_W] <= '0;
            else if (state == ST_APPLY)
                stall_cnt[gc*STALL_W +: STALL_W] <= '0;
            else if (stall_col[gc] && stall_cnt[gc*STALL_W +: STALL_W] != '1)
                stall_cnt[gc*STALL_W +: STALL_W] <= stall_cnt[gc*STALL_W +: STALL_W] + STALL_W'(1);
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_psum_route_fabric.sv
// Directed bench for psum_route_fabric: scoreboard of expected deliveries, immediate-assertion checks.
module tb_psum_route_fabric;
    localparam int ROWS    = 6;
    localparam int COLS    = 7;
    localparam int DW      = 16;
    localparam int STALL_W = 16;
    localparam int N       = ROWS * COLS;

    logic                 clk, rst_n;
    logic [N*DW-1:0]      pe_psum_out, pe_psum_in, seg_out;
    logic [N-1:0]         pe_psum_out_vld, pe_psum_out_ack, pe_psum_in_vld, pe_psum_in_ack;
    logic [N-1:0]         seg_out_vld, seg_out_ack;
    logic [COLS*DW-1:0]   ext_psum_in;
    logic [COLS-1:0]      ext_psum_in_vld, ext_psum_in_ack;
    logic [ROWS-1:0]      cfg_seg_start;
    logic                 cfg_top_ext, cfg_req, cfg_busy, cfg_done, err;
    logic [COLS*STALL_W-1:0] stall_cnt;

    psum_route_fabric #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .STALL_W(STALL_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .pe_psum_out(pe_psum_out), .pe_psum_out_vld(pe_psum_out_vld), .pe_psum_out_ack(pe_psum_out_ack),
        .pe_psum_in(pe_psum_in), .pe_psum_in_vld(pe_psum_in_vld), .pe_psum_in_ack(pe_psum_in_ack),
        .ext_psum_in(ext_psum_in), .ext_psum_in_vld(ext_psum_in_vld), .ext_psum_in_ack(ext_psum_in_ack),
        .seg_out(seg_out), .seg_out_vld(seg_out_vld), .seg_out_ack(seg_out_ack),
        .cfg_seg_start(cfg_seg_start), .cfg_top_ext(cfg_top_ext), .cfg_req(cfg_req),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .stall_cnt(stall_cnt), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit          is_seg;
        int          idx;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    function automatic int idx(input int r, input int c);
        return r * COLS + c;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pe_out(input int r, input int c, input logic [DW-1:0] d, input logic v);
        pe_psum_out[idx(r, c)*DW +: DW] = d;
        pe_psum_out_vld[idx(r, c)]      = v;
    endtask

    task automatic sb_push(input bit is_seg, input int r, input int c, input logic [DW-1:0] d);
        exp_t e;
        e.is_seg = is_seg;
        e.idx    = idx(r, c);
        e.data   = d;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = sb.pop_front();
            if (e.is_seg) begin
                check({tag, "_vld"}, 64'(seg_out_vld[e.idx]), 64'(1));
                check(tag, 64'(seg_out[e.idx*DW +: DW]), 64'(e.data));
            end else begin
                check({tag, "_vld"}, 64'(pe_psum_in_vld[e.idx]), 64'(1));
                check(tag, 64'(pe_psum_in[e.idx*DW +: DW]), 64'(e.data));
            end
        end
    endtask

    task automatic wait_cfg_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (cfg_done) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, 64'(seen), 64'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0]       exp_ack;
        logic [STALL_W-1:0] exp_stall;

        rst_n = 1'b0;
        pe_psum_out = '0; pe_psum_out_vld = '0; pe_psum_in_ack = '0;
        ext_psum_in = '0; ext_psum_in_vld = '0; seg_out_ack = '0;
        cfg_seg_start = '0; cfg_top_ext = 1'b0; cfg_req = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        // Reset while three hops are full and every input is active
        set_pe_out(0, 0, 16'h0101, 1'b1);
        set_pe_out(0, 1, 16'h0102, 1'b1);
        set_pe_out(0, 2, 16'h0103, 1'b1);
        #1 check("fill_ack", 64'(pe_psum_out_ack), 64'(3'b111));
        step();
        check("fill_full", 64'(pe_psum_in_vld[COLS +: 3]), 64'(3'b111));
        pe_psum_out_vld = '1; pe_psum_in_ack = '1; seg_out_ack = '1; ext_psum_in_vld = '1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_ack", 64'(pe_psum_out_ack), 64'(0));
        check("rst_in_vld", 64'(pe_psum_in_vld), 64'(0));
        check("rst_seg_vld", 64'(seg_out_vld), 64'(0));
        check("rst_ext_ack", 64'(ext_psum_in_ack), 64'(0));
        check("rst_busy_done", 64'({cfg_busy, cfg_done}), 64'(0));
        @(posedge clk);
        #2;
        pe_psum_out = '0; pe_psum_out_vld = '0; pe_psum_in_ack = '0;
        seg_out_ack = '0; ext_psum_in_vld = '0;
        rst_n = 1'b1;
        step();
        check("post_rst_err", 64'(err), 64'(0));
        check("post_rst_stall", 64'(stall_cnt[STALL_W-1:0]), 64'(0));
        check("post_rst_row0_vld", 64'(pe_psum_in_vld[0 +: COLS]), 64'(7'h7f));
        check("post_rst_row1_vld", 64'(pe_psum_in_vld[COLS +: COLS]), 64'(0));

        // Default map: row0 -> row1 hop, row 5 exports
        set_pe_out(0, 0, 16'h0011, 1'b1);
        #1 check("t2_ack00", 64'(pe_psum_out_ack[idx(0, 0)]), 64'(1));
        sb_push(1'b0, 1, 0, 16'h0011);
        step();
        pe_psum_out_vld = '0;
        sb_pop("t2_hop10");
        pe_psum_in_ack[idx(1, 0)] = 1'b1;
        step();
        check("t2_hop10_empty", 64'(pe_psum_in_vld[idx(1, 0)]), 64'(0));
        pe_psum_in_ack = '0;

        set_pe_out(5, 0, 16'h00AA, 1'b1);
        #1 check("t2_ack50", 64'(pe_psum_out_ack[idx(5, 0)]), 64'(1));
        sb_push(1'b1, 5, 0, 16'h00AA);
        step();
        pe_psum_out_vld = '0;
        sb_pop("t2_seg50");
        check("t2_seg_rows04", 64'(seg_out_vld[0 +: 5*COLS]), 64'(0));
        seg_out_ack[idx(5, 0)] = 1'b1;
        step();
        check("t2_seg50_empty", 64'(seg_out_vld[idx(5, 0)]), 64'(0));
        seg_out_ack = '0;

        // Reconfigure to segments starting at rows 0 and 3
        cfg_seg_start = 6'b001001; cfg_top_ext = 1'b0; cfg_req = 1'b1;
        step();
        cfg_req = 1'b0;
        set_pe_out(0, 3, 16'h3333, 1'b1);
        #1;
        check("t3_busy", 64'(cfg_busy), 64'(1));
        check("t3_drain_ack", 64'(pe_psum_out_ack), 64'(0));
        check("t3_drain_row0", 64'(pe_psum_in_vld[0 +: COLS]), 64'(0));
        pe_psum_out_vld = '0;
        wait_cfg_done("t3_cfg_done");
        check("t3_not_busy", 64'(cfg_busy), 64'(0));
        check("t3_row3_vld", 64'(pe_psum_in_vld[3*COLS +: COLS]), 64'(7'h7f));
        set_pe_out(2, 4, 16'h1234, 1'b1);
        #1 check("t3_ack24", 64'(pe_psum_out_ack[idx(2, 4)]), 64'(1));
        sb_push(1'b1, 2, 4, 16'h1234);
        step();
        pe_psum_out_vld = '0;
        check("t3_done_pulse", 64'(cfg_done), 64'(0));
        sb_pop("t3_seg24");
        check("t3_row3_in34", 64'({pe_psum_in_vld[idx(3, 4)], pe_psum_in[idx(3, 4)*DW +: DW]}), 64'(17'h10000));
        seg_out_ack[idx(2, 4)] = 1'b1;
        step();
        seg_out_ack = '0;

        // Backpressure on H(5,2) then full throughput
        set_pe_out(5, 2, 16'h0500, 1'b1);
        #1 check("t4_ack_first", 64'(pe_psum_out_ack[idx(5, 2)]), 64'(1));
        sb_push(1'b1, 5, 2, 16'h0500);
        step();
        set_pe_out(5, 2, 16'h0501, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t4_stall_ack", 64'(pe_psum_out_ack[idx(5, 2)]), 64'(0));
            check("t4_hold", 64'({seg_out_vld[idx(5, 2)], seg_out[idx(5, 2)*DW +: DW]}), 64'(17'h10500));
            step();
        end
`ifdef PSUM_FABRIC_STALL_CNT_EN
        exp_stall = STALL_W'(5);
`else
        exp_stall = '0;
`endif
        check("t4_stall_cnt", 64'(stall_cnt[2*STALL_W +: STALL_W]), 64'(exp_stall));
        seg_out_ack[idx(5, 2)] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_pe_out(5, 2, 16'h0501 + 16'(i), 1'b1);
            #1 check("t4_stream_ack", 64'(pe_psum_out_ack[idx(5, 2)]), 64'(1));
            sb_pop("t4_stream");
            sb_push(1'b1, 5, 2, 16'h0501 + 16'(i));
            step();
        end
        pe_psum_out_vld = '0;
        #1 sb_pop("t4_last");
        step();
        check("t4_empty", 64'(seg_out_vld[idx(5, 2)]), 64'(0));
        seg_out_ack = '0;

        // Three hops full, then reconfigure with top_ext=1
        set_pe_out(0, 1, 16'h0A01, 1'b1);
        set_pe_out(1, 1, 16'h0A02, 1'b1);
        set_pe_out(4, 1, 16'h0A03, 1'b1);
        exp_ack = '0;
        exp_ack[idx(0, 1)] = 1'b1; exp_ack[idx(1, 1)] = 1'b1; exp_ack[idx(4, 1)] = 1'b1;
        #1 check("t5_fill_ack", 64'(pe_psum_out_ack), 64'(exp_ack));
        sb_push(1'b0, 1, 1, 16'h0A01);
        sb_push(1'b0, 2, 1, 16'h0A02);
        sb_push(1'b0, 5, 1, 16'h0A03);
        step();
        pe_psum_out_vld = '0;
        cfg_seg_start = 6'b010001; cfg_top_ext = 1'b1; cfg_req = 1'b1;
        step();
        cfg_req = 1'b0;
        pe_psum_out_vld = '1;
        #1;
        check("t5_drain_ack", 64'(pe_psum_out_ack), 64'(0));
        check("t5_busy", 64'(cfg_busy), 64'(1));
        check("t5_drain_row3", 64'(pe_psum_in_vld[3*COLS +: COLS]), 64'(0));
        check("t5_old_map11", 64'({pe_psum_in_vld[idx(1, 1)], pe_psum_in[idx(1, 1)*DW +: DW]}), 64'(17'h10A01));
        pe_psum_out_vld = '0;

        // Second request while busy
        cfg_seg_start = 6'b111111; cfg_top_ext = 1'b0; cfg_req = 1'b1;
        step();
        cfg_req = 1'b0;
        check("t6_err", 64'(err), 64'(1));
        pe_psum_in_ack = '1;
        #1;
        sb_pop("t5_drain11");
        sb_pop("t5_drain21");
        sb_pop("t5_drain51");
        wait_cfg_done("t5_cfg_done");
        check("t5_not_busy", 64'(cfg_busy), 64'(0));
        check("t5_stall_clr", 64'(stall_cnt), 64'(0));
        for (int c = 0; c < COLS; c++) ext_psum_in[c*DW +: DW] = 16'hE000 + 16'(c);
        ext_psum_in_vld = '1;
        #1;
        check("t5_row0_ext", 64'(pe_psum_in[idx(0, 3)*DW +: DW]), 64'(16'hE003));
        check("t5_row0_vld", 64'(pe_psum_in_vld[0 +: COLS]), 64'(7'h7f));
        check("t5_ext_ack", 64'(ext_psum_in_ack), 64'(7'h7f));
        check("t6_first_cfg_row4", 64'(pe_psum_in_vld[4*COLS +: COLS]), 64'(7'h7f));
        check("t6_first_cfg_row3", 64'(pe_psum_in_vld[3*COLS +: COLS]), 64'(0));
        ext_psum_in_vld = '0;
        #1 check("t5_row0_novld", 64'(pe_psum_in_vld[0 +: COLS]), 64'(0));
        step();
        check("t6_err_sticky", 64'(err), 64'(1));
        check("t6_sb_empty", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
